// File: rtl/fifo_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_status_tracker
// Brief    : Occupancy and status tracker for the five QoS FIFOs
//            (bit order [0]=MF, [1]=V0, [2]=V1, [3]=D0, [4]=D1).
//            It produces registered empty, sticky-error and almost-full/empty
//            flags from push/pop strobes and programmable thresholds.
//            Optional macro FIFO_STATUS_OCC_EN adds the occ_total output,
//            which is the aggregate occupancy of all five FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_status_tracker #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        push,
    input  logic [4:0]        pop,
    input  logic              load_th,
    input  logic [ADDR_W:0]   umbral_alto,
    input  logic [ADDR_W:0]   umbral_bajo,
    input  logic              clr_err,
    output logic [4:0]        FIFO_EMPTIES,
    output logic [4:0]        FIFO_ERRORS,
    output logic [4:0]        almost_full,
    output logic [4:0]        almost_empty
`ifdef FIFO_STATUS_OCC_EN
    ,
    output logic [ADDR_W+3:0] occ_total
`endif
);

    localparam int              c_NUM_FIFO = 5;
    // DEPTH = 2**ADDR_W, built as a literal so it carries the counter width
    localparam logic [ADDR_W:0] c_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ALTO_RST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] c_BAJO_RST = {{ADDR_W{1'b0}}, 1'b1};

    logic [c_NUM_FIFO-1:0][ADDR_W:0] r_cnt;
    logic [c_NUM_FIFO-1:0][ADDR_W:0] w_cntNext;
    logic [ADDR_W:0]                 r_alto;
    logic [ADDR_W:0]                 r_bajo;
    logic [ADDR_W:0]                 w_altoNext;
    logic [ADDR_W:0]                 w_bajoNext;
    logic [c_NUM_FIFO-1:0]           w_errEv;
    logic [c_NUM_FIFO-1:0]           w_emptyNext;
    logic [c_NUM_FIFO-1:0]           w_fullNext;
    logic [c_NUM_FIFO-1:0]           w_lowNext;

    // Thresholds are clamped to DEPTH on load; the flags evaluated at the load
    // edge already see the new values, so the flags compare against these nets.
    assign w_altoNext = load_th ? ((umbral_alto > c_DEPTH) ? c_DEPTH : umbral_alto) : r_alto;
    assign w_bajoNext = load_th ? ((umbral_bajo > c_DEPTH) ? c_DEPTH : umbral_bajo) : r_bajo;

    for (genvar i = 0; i < c_NUM_FIFO; i++) begin : g_fifo
        logic [ADDR_W:0] w_next;
        logic            w_err;

        // Saturating next-count and error event; a pop on an empty FIFO is
        // rejected even when a push in the same cycle is accepted.
        always_comb begin
            w_next = r_cnt[i];
            w_err  = 1'b0;
            case ({push[i], pop[i]})
                2'b10: begin
                    if (r_cnt[i] == c_DEPTH) w_err  = 1'b1;
                    else                     w_next = r_cnt[i] + 1'b1;
                end
                2'b01: begin
                    if (r_cnt[i] == '0) w_err  = 1'b1;
                    else                w_next = r_cnt[i] - 1'b1;
                end
                2'b11: begin
                    if (r_cnt[i] == '0) begin
                        w_err  = 1'b1;
                        w_next = c_BAJO_RST;  // count of one
                    end
                end
                default: ;
            endcase
        end

        assign w_cntNext[i]   = w_next;
        assign w_errEv[i]     = w_err;
        assign w_emptyNext[i] = (w_next == '0);
        assign w_fullNext[i]  = (w_next >= w_altoNext);
        assign w_lowNext[i]   = (w_next <= w_bajoNext);
    end

    // Counter, threshold and flag registers; the flags come from next-state
    // values so a strobe shows up right after the edge that samples it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_alto       <= c_ALTO_RST;
            r_bajo       <= c_BAJO_RST;
            FIFO_EMPTIES <= '1;
            FIFO_ERRORS  <= '0;
            almost_full  <= '0;
            almost_empty <= '1;
        end else begin
            r_cnt        <= w_cntNext;
            r_alto       <= w_altoNext;
            r_bajo       <= w_bajoNext;
            FIFO_EMPTIES <= w_emptyNext;
            // A new error event beats clr_err on the same bit
            FIFO_ERRORS  <= (FIFO_ERRORS & {c_NUM_FIFO{~clr_err}}) | w_errEv;
            almost_full  <= w_fullNext;
            almost_empty <= w_lowNext;
        end
    end

`ifdef FIFO_STATUS_OCC_EN
    logic [ADDR_W+3:0] w_occNext;

    // Sum of the five next-state counts
    always_comb begin
        w_occNext = '0;
        for (int k = 0; k < c_NUM_FIFO; k++) begin
            w_occNext = w_occNext + {3'b000, w_cntNext[k]};
        end
    end

    // Registered aggregate occupancy, same timing as the flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) occ_total <= '0;
        else        occ_total <= w_occNext;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_status_tracker
// Brief    : Self-checking bench for fifo_status_tracker: a vector table,
//            hand-written corner sequences and randomized traffic compared
//            against an occupancy model. Honors FIFO_STATUS_OCC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_status_tracker;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        push, pop;
    logic              load_th;
    logic [ADDR_W:0]   umbral_alto, umbral_bajo;
    logic              clr_err;
    logic [4:0]        FIFO_EMPTIES, FIFO_ERRORS, almost_full, almost_empty;
`ifdef FIFO_STATUS_OCC_EN
    logic [ADDR_W+3:0] occ_total;
`endif

    int nTests = 0;
    int nFail  = 0;

    // Reference model state
    int         mCnt [5];
    int         mAlto, mBajo;
    logic [4:0] mErr;

    typedef struct {
        logic [4:0] pu, po;
        logic       ld;
        logic [2:0] ua, ub;
        logic       clr;
        logic [4:0] emp, err, af, ae;
    } vec_t;
    vec_t tbl [10];

    fifo_status_tracker #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .load_th      (load_th),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .clr_err      (clr_err),
        .FIFO_EMPTIES (FIFO_EMPTIES),
        .FIFO_ERRORS  (FIFO_ERRORS),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_STATUS_OCC_EN
        ,
        .occ_total    (occ_total)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 5; i++) mCnt[i] = 0;
        mAlto = DEPTH - 1;
        mBajo = 1;
        mErr  = '0;
    endtask

    // Accepted pops first, then pushes that fit in the space left
    task automatic modelEdge(input logic [4:0] pu, input logic [4:0] po, input logic ld,
                             input logic [2:0] ua, input logic [2:0] ub, input logic clr);
        int popOk, pushOk;
        if (ld) begin
            mAlto = (int'(ua) < DEPTH) ? int'(ua) : DEPTH;
            mBajo = (int'(ub) < DEPTH) ? int'(ub) : DEPTH;
        end
        if (clr) mErr = '0;
        for (int i = 0; i < 5; i++) begin
            popOk  = (po[i] && mCnt[i] > 0) ? 1 : 0;
            pushOk = (pu[i] && (mCnt[i] - popOk) < DEPTH) ? 1 : 0;
            if ((po[i] && popOk == 0) || (pu[i] && pushOk == 0)) mErr[i] = 1'b1;
            mCnt[i] = mCnt[i] + pushOk - popOk;
        end
    endtask

    task automatic checkModel(input string tag);
        logic [4:0] eEmp, eAf, eAe;
        int         eOcc;
        eOcc = 0;
        for (int i = 0; i < 5; i++) begin
            eEmp[i] = (mCnt[i] == 0);
            eAf[i]  = (mCnt[i] >= mAlto);
            eAe[i]  = (mCnt[i] <= mBajo);
            eOcc   += mCnt[i];
        end
        chk({tag, ".empties"}, 32'(FIFO_EMPTIES), 32'(eEmp));
        chk({tag, ".errors"},  32'(FIFO_ERRORS),  32'(mErr));
        chk({tag, ".afull"},   32'(almost_full),  32'(eAf));
        chk({tag, ".aempty"},  32'(almost_empty), 32'(eAe));
`ifdef FIFO_STATUS_OCC_EN
        chk({tag, ".occ"},     32'(occ_total),    32'(eOcc));
`endif
    endtask

    // Drive one cycle of stimulus, sample 1 time unit after the edge
    task automatic step(input logic [4:0] pu, input logic [4:0] po, input logic ld,
                        input logic [2:0] ua, input logic [2:0] ub, input logic clr);
        push = pu; pop = po; load_th = ld;
        umbral_alto = ua; umbral_bajo = ub; clr_err = clr;
        @(posedge clk);
        #1;
        modelEdge(pu, po, ld, ua, ub, clr);
        push = '0; pop = '0; load_th = 1'b0; clr_err = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, ".empties"}, 32'(FIFO_EMPTIES), 32'h1f);
        chk({tag, ".errors"},  32'(FIFO_ERRORS),  32'h00);
        chk({tag, ".afull"},   32'(almost_full),  32'h00);
        chk({tag, ".aempty"},  32'(almost_empty), 32'h1f);
`ifdef FIFO_STATUS_OCC_EN
        chk({tag, ".occ"},     32'(occ_total),    32'h0);
`endif
    endtask

    initial begin
        //             push      pop       ld  ua ub clr  emp       err       af        ae
        tbl[0] = '{5'b00010, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b00000, 5'b00000, 5'b11111};
        tbl[1] = '{5'b00010, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b00000, 5'b00000, 5'b11101};
        tbl[2] = '{5'b00010, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b00000, 5'b00010, 5'b11101};
        tbl[3] = '{5'b00010, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b00000, 5'b00010, 5'b11101};
        tbl[4] = '{5'b00010, 5'b00000, 0, 0, 0, 0, 5'b11101, 5'b00010, 5'b00010, 5'b11101};
        tbl[5] = '{5'b00000, 5'b00000, 0, 0, 0, 1, 5'b11101, 5'b00000, 5'b00010, 5'b11101};
        tbl[6] = '{5'b00010, 5'b00000, 0, 0, 0, 1, 5'b11101, 5'b00010, 5'b00010, 5'b11101};
        tbl[7] = '{5'b00000, 5'b00000, 0, 0, 0, 1, 5'b11101, 5'b00000, 5'b00010, 5'b11101};
        tbl[8] = '{5'b10000, 5'b10000, 0, 0, 0, 0, 5'b01101, 5'b10000, 5'b00010, 5'b11101};
        tbl[9] = '{5'b00000, 5'b00000, 0, 0, 0, 1, 5'b01101, 5'b00000, 5'b00010, 5'b11101};

        reset = 1'b0; push = '0; pop = '0; load_th = 1'b0;
        umbral_alto = '0; umbral_bajo = '0; clr_err = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b1;

        // Vector table: V0 fill/overflow, clr_err races, D1 push+pop on empty
        for (int t = 0; t < 10; t++) begin
            step(tbl[t].pu, tbl[t].po, tbl[t].ld, tbl[t].ua, tbl[t].ub, tbl[t].clr);
            chk($sformatf("tbl%0d.empties", t), 32'(FIFO_EMPTIES), 32'(tbl[t].emp));
            chk($sformatf("tbl%0d.errors", t),  32'(FIFO_ERRORS),  32'(tbl[t].err));
            chk($sformatf("tbl%0d.afull", t),   32'(almost_full),  32'(tbl[t].af));
            chk($sformatf("tbl%0d.aempty", t),  32'(almost_empty), 32'(tbl[t].ae));
        end

        // MF filled, then simultaneous push+pop holds it full without error
        repeat (4) step(5'b00001, 5'b00000, 0, 0, 0, 0);
        checkModel("mf_fill");
        for (int c = 0; c < 10; c++) begin
            step(5'b00001, 5'b00001, 0, 0, 0, 0);
            chk($sformatf("mf_pp%0d.afull0", c),  32'(almost_full[0]),  32'd1);
            chk($sformatf("mf_pp%0d.err0", c),    32'(FIFO_ERRORS[0]),  32'd0);
            chk($sformatf("mf_pp%0d.empty0", c),  32'(FIFO_EMPTIES[0]), 32'd0);
        end
        checkModel("mf_pp");

        // Threshold load with bajo clamped to DEPTH; D0 holds two entries
        repeat (2) step(5'b01000, 5'b00000, 0, 0, 0, 0);
        step(5'b00000, 5'b00000, 1, 3'd2, 3'd7, 0);
        chk("load.afull3",  32'(almost_full[3]),  32'd1);
        chk("load.aempty3", 32'(almost_empty[3]), 32'd1);
        checkModel("load");

        // Asynchronous reset between edges, held across an edge with strobes
        step(5'b10101, 5'b00010, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkResetValues("async_rst");
        modelReset();
        push = 5'b11111; pop = 5'b01010;
        @(posedge clk);
        #1;
        checkResetValues("rst_hold");
        push = '0; pop = '0;
        reset = 1'b1;
        step(5'b01101, 5'b00000, 0, 0, 0, 0);
        chk("post_rst.empties", 32'(FIFO_EMPTIES), 32'b10010);
`ifdef FIFO_STATUS_OCC_EN
        chk("post_rst.occ", 32'(occ_total), 32'd3);
`endif
        checkModel("post_rst");

        // Randomized traffic against the model
        for (int r = 0; r < 400; r++) begin
            step(5'($urandom), 5'($urandom), ($urandom_range(0, 7) == 0),
                 3'($urandom), 3'($urandom), ($urandom_range(0, 5) == 0));
            checkModel($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
